// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32I/RV64I immediate decode stage with a 2-entry skid buffer.
// Optional CSR immediate (Z format) decode is enabled by defining IMM_GEN_STAGE_CSR_EN.
module imm_gen_stage #(
    parameter int XLEN         = 32,
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic signed [31:0] imm_s;
    logic [XLEN-1:0]    dec_imm;
    logic [2:0]         dec_fmt;
    logic               dec_ill;

    logic               skid_valid;
    logic [31:0]        skid_inst;
    logic [XLEN-1:0]    skid_imm;
    logic [2:0]         skid_fmt;
    logic               skid_ill;

    // Decode the incoming word; every RV immediate fits a signed 32-bit value, widened to XLEN at the end.
    always_comb begin
        imm_s   = '0;
        dec_fmt = 3'd0;
        dec_ill = 1'b0;
        case (in_inst[6:0])
            OP_OP: dec_fmt = 3'd0;
            OP_IMM, OP_LOAD, OP_JALR: begin
                dec_fmt = 3'd1;
                imm_s   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OP_STORE: begin
                dec_fmt = 3'd2;
                imm_s   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt = 3'd3;
                imm_s   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = 3'd4;
                imm_s   = {in_inst[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_fmt = 3'd5;
                imm_s   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            OP_SYSTEM: begin
`ifdef IMM_GEN_STAGE_CSR_EN
                dec_fmt = in_inst[14] ? 3'd6 : 3'd0;
                imm_s   = in_inst[14] ? {27'b0, in_inst[19:15]} : 32'sd0;
`else
                dec_fmt = 3'd0;
`endif
            end
            default: dec_ill = 1'b1;
        endcase
        dec_imm = (dec_ill && !ILLEGAL_ZERO) ? {XLEN{1'bx}} : XLEN'(imm_s);
    end

    // Output register plus skid entry; in_ready drops only while the skid entry is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
            skid_valid  <= 1'b0;
            skid_inst   <= '0;
            skid_imm    <= '0;
            skid_fmt    <= '0;
            skid_ill    <= 1'b0;
            in_ready    <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_inst    <= skid_inst;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_ill;
                skid_valid  <= 1'b0;
                in_ready    <= 1'b1;
            end
        end else if (in_valid && in_ready) begin
            if (!out_valid || out_ready) begin
                out_valid   <= 1'b1;
                out_inst    <= in_inst;
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_ill;
            end else begin
                skid_valid <= 1'b1;
                skid_inst  <= in_inst;
                skid_imm   <= dec_imm;
                skid_fmt   <= dec_fmt;
                skid_ill   <= dec_ill;
                in_ready   <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: scoreboard bench driving a 32-bit and a 64-bit instance with identical stimulus.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;

    logic        r32, v32, ill32, r64, v64, ill64;
    logic [31:0] inst32, inst64, imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    imm_gen_stage #(.XLEN(32)) d32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_inst(in_inst), .out_valid(v32), .out_ready(out_ready), .out_inst(inst32),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_stage #(.XLEN(64)) d64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_inst(in_inst), .out_valid(v64), .out_ready(out_ready), .out_inst(inst64),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: field extraction straight from the ISA immediate definitions, sign-extended to 64 bits.
    function automatic exp_t model(input logic [31:0] i);
        exp_t e;
        longint v;
        v = 0;
        e.inst = i;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (i[6:0])
            7'h33: v = 0;
            7'h13, 7'h03, 7'h67: begin e.fmt = 3'd1; v = $signed(i[31:20]); end
            7'h23: begin e.fmt = 3'd2; v = $signed({i[31:25], i[11:7]}); end
            7'h63: begin e.fmt = 3'd3; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
            7'h37, 7'h17: begin e.fmt = 3'd4; v = $signed({i[31:12], 12'b0}); end
            7'h6f: begin e.fmt = 3'd5; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
            7'h73: begin
`ifdef IMM_GEN_STAGE_CSR_EN
                if (i[14]) begin e.fmt = 3'd6; v = longint'(i[19:15]); end
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        return e;
    endfunction

    // Issue one cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v, input logic [31:0] i, input logic r, input logic f);
        in_valid = v;
        in_inst = i;
        out_ready = r;
        flush = f;
        #1;
        if (f) q.delete();
        else if (v && r32) q.push_back(model(i));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0] ops [10];
        int k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73};
        w = $urandom();
        k = $urandom_range(0, 11);
        if (k < 10) w[6:0] = ops[k];
        return w;
    endfunction

    // Monitor: pops the scoreboard whenever an output is taken and compares both instances.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("valid_match", v64, v32);
                chk("ready_match", r64, r32);
                if (!flush && v32 && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pop_empty actual=output inst %h required=no output", inst32);
                    end else begin
                        e = q.pop_front();
                        chk("sb_inst", inst32, e.inst);
                        chk("sb_inst64", inst64, e.inst);
                        chk("sb_imm32", imm32, {32'b0, e.imm[31:0]});
                        chk("sb_imm64", imm64, e.imm);
                        chk("sb_fmt32", fmt32, e.fmt);
                        chk("sb_fmt64", fmt64, e.fmt);
                        chk("sb_ill32", ill32, e.ill);
                        chk("sb_ill64", ill64, e.ill);
                    end
                end
            end
        end
    end

    localparam logic [31:0] A = 32'h00100093;
    localparam logic [31:0] B = 32'h00200113;
    localparam logic [31:0] C = 32'h00300193;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", v32, 0);
        chk("rst_ready", r32, 1);
        chk("rst_inst", inst32, 0);
        chk("rst_imm", imm64, 0);
        chk("rst_fmt", fmt32, 0);
        chk("rst_ill", ill32, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 32'hFFF00093, 1, 0);
        chk("addi_valid", v32, 1);
        chk("addi_imm", imm32, 32'hFFFFFFFF);
        chk("addi_fmt", fmt32, 1);
        chk("addi_ill", ill32, 0);
        step(1, 32'hFE000EE3, 1, 0);
        chk("beq_imm", imm32, 32'hFFFFFFFC);
        chk("beq_fmt", fmt32, 3);
        step(1, 32'h0080006F, 1, 0);
        chk("jal_imm", imm32, 32'h00000008);
        chk("jal_fmt", fmt32, 5);
        step(1, 32'h800000B7, 1, 0);
        chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("lui_imm32", imm32, 32'h80000000);
        chk("lui_fmt", fmt64, 4);
        step(1, 32'h00000000, 1, 0);
        chk("zero_ill", ill32, 1);
        chk("zero_imm", imm32, 0);
        chk("zero_fmt", fmt32, 0);
        step(1, 32'h3002D073, 1, 0);
`ifdef IMM_GEN_STAGE_CSR_EN
        chk("csr_imm", imm32, 5);
        chk("csr_fmt", fmt32, 6);
`else
        chk("csr_imm", imm32, 0);
        chk("csr_fmt", fmt32, 0);
`endif
        chk("csr_ill", ill32, 0);
        step(0, 0, 1, 0);
        chk("idle_valid", v32, 0);

        step(1, A, 0, 0);
        chk("bp1_ready", r32, 1);
        step(1, B, 0, 0);
        chk("bp2_ready", r32, 0);
        chk("bp2_out", inst32, A);
        step(1, C, 0, 0);
        chk("bp3_ready", r32, 0);
        chk("bp3_out", inst32, A);
        step(1, C, 1, 0);
        chk("bp_drain_out", inst32, B);
        chk("bp_drain_ready", r32, 1);
        step(1, C, 1, 0);
        chk("bp_third_out", inst32, C);
        step(0, 0, 1, 0);
        chk("bp_empty", v32, 0);

        step(1, A, 0, 0);
        step(1, B, 0, 0);
        chk("fl_full", r32, 0);
        step(1, C, 0, 1);
        chk("fl_valid", v32, 0);
        chk("fl_ready", r32, 1);
        repeat (3) step(0, 0, 1, 0);
        chk("fl_quiet", v32, 0);

        step(1, A, 0, 0);
        step(1, B, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", v32, 0);
        chk("ar_ready", r32, 1);
        chk("ar_inst", inst32, 0);
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_after", v32, 0);

        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 9) < 7, rand_inst(), $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        for (int n = 0; n < 20 && (q.size() != 0 || v32); n++)
            step(0, 0, 1, 0);
        chk("drain_empty", 64'(q.size()), 0);
        chk("drain_valid", v32, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
